// File: rtl/pal_pkg.sv
// Shared types and fuse-map geometry for the serially configured PAL array.
// All offsets are indices into the flat fuse register, bit 0 loaded first.
package pal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } pal_state_e;

    function automatic int and_bits(input int num_products, input int ni_eff);
        return num_products * 2 * ni_eff;
    endfunction

    function automatic int or_off(input int num_products, input int ni_eff);
        return and_bits(num_products, ni_eff);
    endfunction

    function automatic int mode_off(input int num_products, input int num_outputs, input int ni_eff);
        return or_off(num_products, ni_eff) + num_outputs * num_products;
    endfunction

    function automatic int pol_off(input int num_products, input int num_outputs, input int ni_eff);
        return mode_off(num_products, num_outputs, ni_eff) + num_outputs;
    endfunction

    function automatic int cfg_bits(input int num_products, input int num_outputs, input int ni_eff);
        return pol_off(num_products, num_outputs, ni_eff) + num_outputs;
    endfunction

    // Counter must be able to hold CFG_BITS itself, not just the last index.
    function automatic int cnt_width(input int n_cfg_bits);
        return $clog2(n_cfg_bits + 1);
    endfunction

endpackage

// File: rtl/pal_cfg_loader.sv
// Serial fuse loader: IDLE/LOAD/RUN sequencing, bit counter and fuse register.
// A start pulse in any state restarts the load and discards any bit offered with it.
module pal_cfg_loader
    import pal_pkg::*;
#(
    parameter int CFG_BITS = 48
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_cfg_start,
    input  logic                i_cfg_valid,
    input  logic                i_cfg_bit,
    output logic                o_cfg_ready,
    output logic                o_cfg_done,
    output logic [CFG_BITS-1:0] o_fuse
);

    localparam int CNT_W = cnt_width(CFG_BITS);

    pal_state_e          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CFG_BITS-1:0] r_fuse;
    logic                r_ready;
    logic                r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_fuse  <= '0;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_cfg_start) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
            r_fuse  <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else if (r_state == ST_LOAD && i_cfg_valid) begin
            // Decoded write keeps the index width independent of CNT_W.
            for (int i = 0; i < CFG_BITS; i++) begin
                if (r_cnt == CNT_W'(i)) begin
                    r_fuse[i] <= i_cfg_bit;
                end
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(CFG_BITS - 1)) begin
                r_state <= ST_RUN;
                r_ready <= 1'b0;
                r_done  <= 1'b1;
            end
        end
    end

    assign o_cfg_ready = r_ready;
    assign o_cfg_done  = r_done;
    assign o_fuse      = r_fuse;

endmodule

// File: rtl/pal_config_array.sv
// Run-time programmable PAL: AND plane, OR plane and per-output macrocells.
// Define PAL_FEEDBACK_EN to feed the registered macrocell outputs back as AND-plane literals.
module pal_config_array
    import pal_pkg::*;
#(
    parameter int NUM_INPUTS   = 3,
    parameter int NUM_PRODUCTS = 4,
    parameter int NUM_OUTPUTS  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_INPUTS-1:0]  din,
    output logic [NUM_OUTPUTS-1:0] dout,
    input  logic                   cfg_start,
    input  logic                   cfg_valid,
    input  logic                   cfg_bit,
    output logic                   cfg_ready,
    output logic                   cfg_done
);

`ifdef PAL_FEEDBACK_EN
    localparam int NI_EFF = NUM_INPUTS + NUM_OUTPUTS;
`else
    localparam int NI_EFF = NUM_INPUTS;
`endif
    localparam int OR_OFF   = or_off(NUM_PRODUCTS, NI_EFF);
    localparam int MODE_OFF = mode_off(NUM_PRODUCTS, NUM_OUTPUTS, NI_EFF);
    localparam int POL_OFF  = pol_off(NUM_PRODUCTS, NUM_OUTPUTS, NI_EFF);
    localparam int CFG_BITS = cfg_bits(NUM_PRODUCTS, NUM_OUTPUTS, NI_EFF);
    localparam int LIT_W    = 2 * NI_EFF;

    logic [CFG_BITS-1:0]     w_fuse;
    logic                    w_run;
    logic [NI_EFF-1:0]       w_x;
    logic [NUM_PRODUCTS-1:0] w_prod;
    logic [NUM_OUTPUTS-1:0]  w_sum;
    logic [NUM_OUTPUTS-1:0]  w_mode;
    logic [NUM_OUTPUTS-1:0]  w_pol;
    logic [NUM_OUTPUTS-1:0]  w_next;
    logic [NUM_OUTPUTS-1:0]  r_q;

    pal_cfg_loader #(
        .CFG_BITS (CFG_BITS)
    ) u_loader (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cfg_start (cfg_start),
        .i_cfg_valid (cfg_valid),
        .i_cfg_bit   (cfg_bit),
        .o_cfg_ready (cfg_ready),
        .o_cfg_done  (cfg_done),
        .o_fuse      (w_fuse)
    );

    assign w_run = cfg_done;

`ifdef PAL_FEEDBACK_EN
    assign w_x = {r_q, din};
`else
    assign w_x = din;
`endif

    // An unprogrammed product term must read 0, not the empty AND (1).
    function automatic logic eval_product(input logic [LIT_W-1:0] sel, input logic [NI_EFF-1:0] x);
        logic v_any;
        logic v_all;
        v_any = 1'b0;
        v_all = 1'b1;
        for (int i = 0; i < NI_EFF; i++) begin
            if (sel[2*i]) begin
                v_any = 1'b1;
                v_all = v_all & x[i];
            end
            if (sel[2*i+1]) begin
                v_any = 1'b1;
                v_all = v_all & ~x[i];
            end
        end
        return v_any & v_all;
    endfunction

    always_comb begin
        w_prod = '0;
        w_sum  = '0;
        for (int p = 0; p < NUM_PRODUCTS; p++) begin
            w_prod[p] = eval_product(w_fuse[p*LIT_W +: LIT_W], w_x);
        end
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            w_sum[o] = |(w_prod & w_fuse[OR_OFF + o*NUM_PRODUCTS +: NUM_PRODUCTS]);
        end
    end

    assign w_mode = w_fuse[MODE_OFF +: NUM_OUTPUTS];
    assign w_pol  = w_fuse[POL_OFF +: NUM_OUTPUTS];
    assign w_next = w_sum ^ w_pol;

    // Combinational-mode cells keep q at 0 so they never appear as feedback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (cfg_start) begin
            r_q <= '0;
        end else if (w_run) begin
            r_q <= w_next & w_mode;
        end
    end

    assign dout = w_run ? ((w_mode & r_q) | (~w_mode & w_next)) : '0;

endmodule

// File: tb/tb_pal_config_array.sv
// Randomized self-checking bench for pal_config_array against a behavioural fuse-map model.
`timescale 1ns/1ps
module tb_pal_config_array;

    localparam int NI = 3;
    localparam int NP = 4;
    localparam int NO = 4;
`ifdef PAL_FEEDBACK_EN
    localparam int NIE = NI + NO;
`else
    localparam int NIE = NI;
`endif
    localparam int ANDB = NP * 2 * NIE;
    localparam int MODEB = ANDB + NO * NP;
    localparam int POLB = MODEB + NO;
    localparam int CFG = POLB + NO;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NI-1:0] din = '0;
    logic [NO-1:0] dout;
    logic          cfg_start = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_bit = 1'b0;
    logic          cfg_ready;
    logic          cfg_done;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pal_config_array #(
        .NUM_INPUTS   (NI),
        .NUM_PRODUCTS (NP),
        .NUM_OUTPUTS  (NO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .dout      (dout),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done)
    );

    // Behavioural model: 0 = unconfigured, 1 = loading, 2 = running.
    bit m_fuse[CFG];
    int m_state = 0;
    int m_cnt = 0;
    bit m_q[NO];
    bit m_nq[NO];

    function automatic bit m_lit(input int idx);
        if (idx < NI) return din[idx];
        return m_q[idx - NI];
    endfunction

    function automatic bit m_sum(input int o);
        bit s;
        bit ok;
        int used;
        s = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (m_fuse[ANDB + o*NP + p]) begin
                used = 0;
                ok = 1'b1;
                for (int j = 0; j < 2*NIE; j++) begin
                    if (m_fuse[p*2*NIE + j]) begin
                        used++;
                        if (j % 2 == 0) ok = ok & m_lit(j/2);
                        else            ok = ok & !m_lit(j/2);
                    end
                end
                if (used > 0 && ok) s = 1'b1;
            end
        end
        return s;
    endfunction

    function automatic logic [NO-1:0] exp_dout();
        logic [NO-1:0] r;
        r = '0;
        if (m_state == 2) begin
            for (int o = 0; o < NO; o++) begin
                if (m_fuse[MODEB + o]) r[o] = m_q[o];
                else                   r[o] = m_sum(o) ^ m_fuse[POLB + o];
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0;
            m_cnt = 0;
            foreach (m_fuse[i]) m_fuse[i] = 1'b0;
            foreach (m_q[i]) m_q[i] = 1'b0;
        end else if (cfg_start) begin
            m_state = 1;
            m_cnt = 0;
            foreach (m_fuse[i]) m_fuse[i] = 1'b0;
            foreach (m_q[i]) m_q[i] = 1'b0;
        end else if (m_state == 1) begin
            if (cfg_valid) begin
                m_fuse[m_cnt] = cfg_bit;
                m_cnt++;
                if (m_cnt == CFG) m_state = 2;
            end
        end else if (m_state == 2) begin
            for (int o = 0; o < NO; o++)
                m_nq[o] = m_fuse[MODEB + o] ? (m_sum(o) ^ m_fuse[POLB + o]) : 1'b0;
            for (int o = 0; o < NO; o++) m_q[o] = m_nq[o];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            check("cycle_dout", 32'(dout), 32'(exp_dout()));
            check("cycle_ready", 32'(cfg_ready), 32'(m_state == 1));
            check("cycle_done", 32'(cfg_done), 32'(m_state == 2));
        end
    end

    // Starts a load and offers bits with random gaps until stop_after are accepted.
    task automatic load_cfg(input logic [CFG-1:0] v, input int stop_after);
        int n;
        n = 0;
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit = 1'b1;
        din = NI'($urandom);
        @(negedge clk);
        cfg_start = 1'b0;
        while (n < stop_after) begin
            cfg_valid = ($urandom_range(0, 3) != 0);
            cfg_bit = v[n];
            din = NI'($urandom);
            @(posedge clk);
            #1;
            if (cfg_valid) n++;
            check("done_edge", 32'(cfg_done), 32'(n == CFG));
            if (n < CFG) check("dout_in_load", 32'(dout), 32'h0);
            @(negedge clk);
        end
        cfg_valid = 1'b0;
    endtask

    logic [CFG-1:0] v;

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("por_dout", 32'(dout), 32'h0);
        check("por_done", 32'(cfg_done), 32'h0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            cfg_valid = 1'b1;
            cfg_bit = 1'b1;
            din = NI'($urandom);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        check("idle_ready", 32'(cfg_ready), 32'h0);

        // Directed map: p0=x0&x1, p1=~x2, out0 comb, out1 registered, out2 empty+inverted.
        v = '0;
        v[0] = 1'b1;
        v[2] = 1'b1;
        v[2*NIE + 5] = 1'b1;
        v[ANDB + 0] = 1'b1;
        v[ANDB + NP + 1] = 1'b1;
        v[MODEB + 1] = 1'b1;
        v[POLB + 2] = 1'b1;
        load_cfg($urandom, 20);
        load_cfg(v, CFG);

        din = 3'b011;
        #1 check("comb_011", 32'(dout[0]), 32'h1);
        @(negedge clk);
        din = 3'b001;
        #1 check("comb_001", 32'(dout[0]), 32'h0);
        @(negedge clk);
        din = 3'b000;
        @(posedge clk);
        #1 check("reg_set", 32'(dout[1]), 32'h1);
        @(negedge clk);
        din = 3'b100;
        #1 check("reg_hold", 32'(dout[1]), 32'h1);
        @(posedge clk);
        #1 check("reg_update", 32'(dout[1]), 32'h0);
        for (int d = 0; d < 8; d++) begin
            @(negedge clk);
            din = NI'(d);
            #1 check("pol_empty", 32'(dout[2]), 32'h1);
        end

        // Asynchronous reset mid-cycle while running.
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_dout", 32'(dout), 32'h0);
        check("arst_ready", 32'(cfg_ready), 32'h0);
        check("arst_done", 32'(cfg_done), 32'h0);
        repeat (3) begin
            @(negedge clk);
            cfg_valid = 1'b1;
            cfg_bit = 1'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            cfg_bit = 1'($urandom);
        end
        #1 check("idle_after_rst", 32'(cfg_done), 32'h0);
        cfg_valid = 1'b0;

        // Random fuse maps with sparse AND planes and random inputs.
        repeat (6) begin
            for (int i = 0; i < CFG; i++)
                v[i] = (i < ANDB) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
            load_cfg(v, CFG);
            repeat (40) begin
                @(negedge clk);
                din = NI'($urandom);
                cfg_valid = 1'($urandom);
                cfg_bit = 1'($urandom);
            end
            cfg_valid = 1'b0;
        end

`ifdef PAL_FEEDBACK_EN
        // Two-bit counter: q0' = ~q0, q1' = q1^q0, with x3=q0, x4=q1.
        v = '0;
        v[7] = 1'b1;
        v[2*NIE + 8] = 1'b1;
        v[2*NIE + 7] = 1'b1;
        v[4*NIE + 9] = 1'b1;
        v[4*NIE + 6] = 1'b1;
        v[ANDB + 0] = 1'b1;
        v[ANDB + NP + 1] = 1'b1;
        v[ANDB + NP + 2] = 1'b1;
        v[MODEB + 0] = 1'b1;
        v[MODEB + 1] = 1'b1;
        load_cfg(v, CFG);
        #1 check("cnt_start", 32'(dout[1:0]), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1 check("cnt_step", 32'(dout[1:0]), 32'(k % 4));
        end
`endif

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
